// File: rtl/softmax_output_serializer.sv
// Serializes one pseudo-softmax result (shared mantissa + per-class exponents) into NUM_CLASSES beats.
// Ports: in_valid/in_ready/mant_in/exp_bus capture side; out_valid/out_ready/out_mant/out_exp/out_idx/out_last stream side; argmax_valid/argmax_idx with SOFTMAX_ARGMAX_EN.
module softmax_output_serializer #(
  parameter int NUM_CLASSES = 10,
  parameter int DATA_WIDTH  = 8
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [DATA_WIDTH-1:0]             mant_in,
  input  logic [NUM_CLASSES*DATA_WIDTH-1:0] exp_bus,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [DATA_WIDTH-1:0]             out_mant,
  output logic [DATA_WIDTH-1:0]             out_exp,
  output logic [3:0]                        out_idx,
  output logic                              out_last
`ifdef SOFTMAX_ARGMAX_EN
  ,
  output logic                              argmax_valid,
  output logic [3:0]                        argmax_idx
`endif
);

  localparam logic [3:0] LAST = 4'(NUM_CLASSES - 1);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] mant_q, mant_d;
  logic [DATA_WIDTH-1:0] exp_q [NUM_CLASSES];
  logic [DATA_WIDTH-1:0] exp_d [NUM_CLASSES];
  logic                  streaming;
  logic                  capture;
  logic                  fire;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mant_d    = mant_q;
    exp_d     = exp_q;
    streaming = (state_q == STREAM);
    in_ready  = !streaming;
    capture   = !streaming && in_valid;
    out_valid = streaming;
    out_mant  = '0;
    out_exp   = '0;
    out_idx   = '0;
    out_last  = 1'b0;
    if (streaming) begin
      out_mant = mant_q;
      out_exp  = exp_q[cnt_q];
      out_idx  = cnt_q;
      out_last = (cnt_q == LAST);
    end
    fire = out_valid && out_ready;
    if (capture) begin
      mant_d = mant_in;
      for (int k = 0; k < NUM_CLASSES; k++)
        exp_d[k] = exp_bus[k*DATA_WIDTH +: DATA_WIDTH];
      cnt_d   = '0;
      state_d = STREAM;
    end else if (fire) begin
      // counter parks on the last index; next capture clears it
      if (out_last) state_d = IDLE;
      else          cnt_d   = cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mant_q  <= '0;
      for (int k = 0; k < NUM_CLASSES; k++)
        exp_q[k] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mant_q  <= mant_d;
      exp_q   <= exp_d;
    end
  end

`ifdef SOFTMAX_ARGMAX_EN
  logic [DATA_WIDTH-1:0] max_q, max_d;
  logic [3:0]            best_q, best_d;
  logic [3:0]            am_idx_q, am_idx_d;
  logic                  am_v_q, am_v_d;
  logic                  better;

  always_comb begin
    max_d    = max_q;
    best_d   = best_q;
    am_idx_d = am_idx_q;
    am_v_d   = 1'b0;
    // strict compare keeps ties on the lowest index
    better   = (cnt_q == '0) || (out_exp > max_q);
    if (capture) am_idx_d = '0;
    if (fire) begin
      if (better) begin
        max_d  = out_exp;
        best_d = cnt_q;
      end
      if (out_last) begin
        am_v_d   = 1'b1;
        am_idx_d = better ? cnt_q : best_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      max_q    <= '0;
      best_q   <= '0;
      am_idx_q <= '0;
      am_v_q   <= 1'b0;
    end else begin
      max_q    <= max_d;
      best_q   <= best_d;
      am_idx_q <= am_idx_d;
      am_v_q   <= am_v_d;
    end
  end

  assign argmax_valid = am_v_q;
  assign argmax_idx   = am_idx_q;
`endif

endmodule

// File: tb/tb_softmax_output_serializer.sv
// Randomized bench for softmax_output_serializer against a queue-based beat model.
// Drives inputs at posedge+1, checks every output at negedge.
module tb_softmax_output_serializer;

  localparam int N  = 10;
  localparam int DW = 8;

  typedef struct {
    logic [7:0] mant;
    logic [7:0] exp;
    logic [3:0] idx;
    logic       last;
  } beat_t;

  logic          clk = 0;
  logic          rst_n = 0;
  logic          in_valid = 0;
  logic          in_ready;
  logic [DW-1:0] mant_in = 0;
  logic [N*DW-1:0] exp_bus = 0;
  logic          out_valid;
  logic          out_ready = 1;
  logic [DW-1:0] out_mant;
  logic [DW-1:0] out_exp;
  logic [3:0]    out_idx;
  logic          out_last;
`ifdef SOFTMAX_ARGMAX_EN
  logic          argmax_valid;
  logic [3:0]    argmax_idx;
`endif

  softmax_output_serializer #(.NUM_CLASSES(N), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .mant_in(mant_in), .exp_bus(exp_bus),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_mant(out_mant), .out_exp(out_exp),
    .out_idx(out_idx), .out_last(out_last)
`ifdef SOFTMAX_ARGMAX_EN
    , .argmax_valid(argmax_valid), .argmax_idx(argmax_idx)
`endif
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;
  beat_t q[$];
  bit run = 0;
  bit acc = 0;
  int mode = 0;
  logic [3:0] cur_best = 0;
  logic [3:0] am_i = 0;
  logic       am_v = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // reference model: a capture expands into N expected beats
  always @(negedge clk) begin
    if (rst_n && run) begin
      bit idle;
      beat_t b;
      idle = (q.size() == 0);
`ifdef SOFTMAX_ARGMAX_EN
      check("am_valid", {31'd0, argmax_valid}, {31'd0, am_v});
      check("am_idx", {28'd0, argmax_idx}, {28'd0, am_i});
`endif
      am_v = 0;
      check("in_ready", {31'd0, in_ready}, {31'd0, idle});
      check("out_valid", {31'd0, out_valid}, {31'd0, !idle});
      if (!idle) begin
        b = q[0];
        check("beat", {11'd0, out_mant, out_exp, out_idx, out_last},
              {11'd0, b.mant, b.exp, b.idx, b.last});
        if (out_ready) begin
          void'(q.pop_front());
          if (b.last) begin
            am_v = 1;
            am_i = cur_best;
          end
        end
      end else begin
        check("idle_zero", {11'd0, out_mant, out_exp, out_idx, out_last}, 32'd0);
      end
      acc = 0;
      if (in_valid && idle) begin
        acc = 1;
        am_i = 0;
        cur_best = 0;
        for (int k = 0; k < N; k++) begin
          beat_t nb;
          nb.mant = mant_in;
          nb.exp  = exp_bus[k*DW +: DW];
          nb.idx  = 4'(k);
          nb.last = (k == N - 1);
          q.push_back(nb);
          if (nb.exp > exp_bus[cur_best*DW +: DW]) cur_best = 4'(k);
        end
      end
    end
  end

  always @(posedge clk) begin
    #1;
    case (mode)
      0: out_ready = 1;
      1: out_ready = ~out_ready;
      default: out_ready = 1'($urandom);
    endcase
  end

  function automatic logic [N*DW-1:0] ramp(input logic [7:0] base);
    logic [N*DW-1:0] e;
    for (int k = 0; k < N; k++) e[k*DW +: DW] = base + 8'(k);
    return e;
  endfunction

  function automatic logic [N*DW-1:0] rnd_exps();
    logic [N*DW-1:0] e;
    for (int k = 0; k < N; k++)
      e[k*DW +: DW] = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
    return e;
  endfunction

  // holds the result until accepted; leaves in_valid asserted
  task automatic send(input logic [7:0] m, input logic [N*DW-1:0] e);
    int n = 0;
    in_valid = 1;
    mant_in  = m;
    exp_bus  = e;
    do begin
      @(posedge clk);
      n++;
    end while (!acc && n < 400);
    #1;
    check("send_accept", {31'd0, acc}, 32'd1);
  endtask

  task automatic drain();
    int n = 0;
    in_valid = 0;
    do begin
      @(posedge clk);
      n++;
    end while (q.size() != 0 && n < 600);
    #1;
    check("drain", q.size(), 32'd0);
  endtask

  initial begin
    logic [N*DW-1:0] e;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out", {11'd0, out_valid, out_mant, out_exp, out_idx, out_last}, 32'd0);
    rst_n = 1;
    run = 1;
    @(posedge clk);
    #1;

    mode = 0;
    send(8'h9C, ramp(8'h10));
    drain();

    mode = 1;
    send(8'h9C, ramp(8'h10));
    drain();

    mode = 0;
    send(8'hA1, ramp(8'h40));
    send(8'h3B, ramp(8'hC0));
    drain();

    send(8'h55, ramp(8'h20));
    in_valid = 0;
    begin
      int n = 0;
      do begin
        @(posedge clk);
        #1;
        n++;
      end while (!(out_valid && out_idx == 4) && n < 50);
      check("reach_idx4", {28'd0, out_idx}, 32'd4);
    end
    rst_n = 0;
    #1;
    check("abort_valid", {31'd0, out_valid}, 32'd0);
    check("abort_ready", {31'd0, in_ready}, 32'd1);
    check("abort_idx", {28'd0, out_idx}, 32'd0);
    q.delete();
    am_v = 0;
    am_i = 0;
    acc = 0;
    @(posedge clk);
    #1;
    rst_n = 1;
    @(posedge clk);
    #1;
    send(8'h77, ramp(8'h01));
    drain();

    e = '0;
    e[0*DW +: DW] = 8'h05;
    e[1*DW +: DW] = 8'h7F;
    e[2*DW +: DW] = 8'h20;
    e[3*DW +: DW] = 8'h7F;
    send(8'h11, e);
    drain();
    repeat (2) @(posedge clk);
    #1;

    mode = 2;
    for (int r = 0; r < 30; r++) begin
      send(8'($urandom), rnd_exps());
      if ($urandom_range(0, 1) == 0) begin
        in_valid = 0;
        repeat ($urandom_range(0, 12)) @(posedge clk);
        #1;
      end
    end
    drain();
    repeat (3) @(posedge clk);
    #1;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
